// File: rtl/uart_transmitter.sv
// UART transmit engine: start, data (LSB first), optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and a line-break state.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
`ifdef UART_TX_BREAK_EN
  , parameter int BREAK_BITS = 13
`endif
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic       parity,
  input  logic       parity_type,
  input  logic       stop_bits,
  input  logic [3:0] frame_length,
  input  logic [8:0] data,
  input  logic       data_valid,
`ifdef UART_TX_BREAK_EN
  input  logic       send_break,
`endif
  output logic       ready,
  output logic       Tx,
  output logic       tx_done,
  output logic [2:0] state_o
);

  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_BRK_STOP
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    len_q, len_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          stop2_q, stop2_d;
  logic          tx_q, tx_d;

  logic [3:0] len_c;
  logic [8:0] data_c;
  logic       bit_end;

  // Handshake: a word transfers on the rising edge where data_valid and ready are
  // both high; ready is high exactly while the engine sits in IDLE.
  assign ready   = (state_q == S_IDLE);
  assign Tx      = tx_q;
  assign state_o = state_q;

  always_comb begin
    len_c   = (frame_length < 4'd5) ? 4'd5 : (frame_length > 4'd9) ? 4'd9 : frame_length;
    data_c  = data & (9'h1FF >> (4'd9 - len_c));
    bit_end = (tick_q == TW'(OVERSAMPLE - 1));
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    tx_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
        end else
`endif
        if (data_valid) begin
          state_d   = S_START;
          tx_d      = 1'b0;
          shift_d   = data_c;
          len_d     = len_c;
          par_en_d  = parity;
          par_bit_d = (^data_c) ^ parity_type;
          stop2_d   = stop_bits;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_q == {4'b0, len_q} - 8'd1) begin
          state_d = par_en_q ? S_PARITY : S_STOP1;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
        end else begin
          bit_d   = bit_q + 8'd1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP1;
        tx_d    = 1'b1;
      end
      S_STOP1: if (bit_end) begin
        state_d = stop2_q ? S_STOP2 : S_IDLE;
        tx_done = !stop2_q;
      end
      S_STOP2: if (bit_end) begin
        state_d = S_IDLE;
        tx_done = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: if (bit_end) begin
        if (bit_q == 8'(BREAK_BITS - 1)) begin
          state_d = S_BRK_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 8'd1;
        end
      end
      S_BRK_STOP: if (bit_end) begin
        state_d = S_IDLE;
        tx_done = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      len_q     <= 4'd5;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter; expected bit strings are listed in transmit order.
// Define UART_TX_BREAK_EN to also exercise the break sequence.
module tb_uart_transmitter;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       parity, parity_type, stop_bits, data_valid;
  logic [3:0] frame_length;
  logic [8:0] data;
  logic       ready, tx, tx_done;
  logic [2:0] state;
`ifdef UART_TX_BREAK_EN
  logic       send_break = 1'b0;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk_16bd     (clk),
    .rst          (rst),
    .parity       (parity),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .frame_length (frame_length),
    .data         (data),
    .data_valid   (data_valid),
`ifdef UART_TX_BREAK_EN
    .send_break   (send_break),
`endif
    .ready        (ready),
    .Tx           (tx),
    .tx_done      (tx_done),
    .state_o      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present a word on the negedge; returns just after the accepting posedge.
  task automatic send(input logic [8:0] d, input logic p, input logic pt,
                      input logic sb, input logic [3:0] len);
    @(negedge clk);
    data = d; parity = p; parity_type = pt; stop_bits = sb; frame_length = len;
    data_valid = 1'b1;
    chk("ready_before_accept", 32'(ready), 32'd1);
    @(posedge clk);
  endtask

  // Checks each bit at its first and last cycle, tx_done only on the final cycle,
  // then the idle cycle that follows.
  task automatic expect_frame(input string tag, input string bits, input bit keep);
    int dones;
    int n;
    logic exp_bit;
    dones = 0;
    n = bits.len();
    for (int b = 0; b < n; b++) begin
      exp_bit = (bits[b] == 8'd49);
      for (int c = 0; c < OS; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) begin
          chk({tag, "_ready_low"}, 32'(ready), 32'd0);
          if (!keep) data_valid = 1'b0;
        end
        if (c == 0 || c == OS - 1)
          chk($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(tx), 32'(exp_bit));
        if (b == n - 1 && c == OS - 1) chk({tag, "_done_last"}, 32'(tx_done), 32'd1);
        else dones += int'(tx_done);
      end
    end
    chk({tag, "_done_early"}, 32'(dones), 32'd0);
    @(negedge clk);
    chk({tag, "_gap_tx"}, 32'(tx), 32'd1);
    chk({tag, "_gap_ready"}, 32'(ready), 32'd1);
    chk({tag, "_gap_done"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    int dones;
    int bad;
    rst = 1'b1; data_valid = 1'b0; parity = 1'b0; parity_type = 1'b0;
    stop_bits = 1'b0; frame_length = 4'd8; data = 9'h0;
    #2;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 0x65, 8 bits, even parity, one stop
    send(9'h065, 1'b1, 1'b0, 1'b0, 4'd8);
    expect_frame("even_65", "01010011001", 1'b0);
    // odd parity on the same word, then even parity on 0x47
    send(9'h065, 1'b1, 1'b1, 1'b0, 4'd8);
    expect_frame("odd_65", "01010011011", 1'b0);
    send(9'h047, 1'b1, 1'b0, 1'b0, 4'd8);
    expect_frame("even_47", "01110001001", 1'b0);
    // no parity, two stop bits
    send(9'h065, 1'b0, 1'b0, 1'b1, 4'd8);
    expect_frame("np2s_65", "01010011011", 1'b0);
    // length clamping
    send(9'h1FF, 1'b1, 1'b0, 1'b0, 4'd5);
    expect_frame("len5", "01111111", 1'b0);
    send(9'h1E0, 1'b0, 1'b0, 1'b0, 4'd0);
    expect_frame("len0", "0000001", 1'b0);
    send(9'h155, 1'b1, 1'b0, 1'b0, 4'd12);
    expect_frame("len12", "010101010111", 1'b0);

    // back-to-back with data_valid held; inputs change mid-frame
    send(9'h065, 1'b1, 1'b0, 1'b0, 4'd8);
    #1;
    data = 9'h0A3; parity_type = 1'b1; frame_length = 4'd8; parity = 1'b1;
    expect_frame("b2b_65", "01010011001", 1'b1);
    expect_frame("b2b_A3", "01100010111", 1'b0);

    // reset during the data bits
    send(9'h065, 1'b1, 1'b0, 1'b0, 4'd8);
    dones = 0;
    for (int i = 0; i < 3 * OS + 5; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      dones += int'(tx_done);
    end
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(tx_done), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2 * OS; i++) begin
      @(negedge clk);
      dones += int'(tx_done);
      bad += int'(!tx);
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    chk("midrst_line_idle", 32'(bad), 32'd0);
    send(9'h047, 1'b1, 1'b0, 1'b1, 4'd8);
    expect_frame("post_rst_47", "011100010011", 1'b0);

`ifdef UART_TX_BREAK_EN
    // break wins over a pending word: 13 low bit periods then one high
    @(negedge clk);
    send_break = 1'b1;
    data = 9'h065; data_valid = 1'b1;
    chk("brk_ready_before", 32'(ready), 32'd1);
    @(posedge clk);
    #1 send_break = 1'b0;
    expect_frame("break", "00000000000001", 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
